// File: rtl/tdm_demux_4ch_if.sv
// Bundles the serial side (en/din/sync) and the demultiplexed side
// (o0..o3 plus status) of the four-channel TDM demultiplexer.
interface tdm_demux_4ch_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] din;
    logic             sync;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic [WIDTH-1:0] o3;
    logic [1:0]       slot;
    logic             locked;
    logic             frame_valid;
    logic             sync_err;

    // Link side: drives slots in, observes decoded frames.
    modport master (
        output en, din, sync,
        input  o0, o1, o2, o3, slot, locked, frame_valid, sync_err
    );

    // Demultiplexer side.
    modport slave (
        input  en, din, sync,
        output o0, o1, o2, o3, slot, locked, frame_valid, sync_err
    );
endinterface

// File: rtl/tdm_demux_4ch.sv
// Receive end of a 4-slot TDM link. Locks onto the frame-sync marker,
// gathers slots 0..2 in shadow registers and publishes all four channel
// outputs together when slot 3 arrives, so o0..o3 never mix two frames.
module tdm_demux_4ch #(
    parameter int WIDTH = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux_4ch_if.slave bus
);
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] sh2_q, sh2_d;
    logic [WIDTH-1:0] o0_q, o0_d;
    logic [WIDTH-1:0] o1_q, o1_d;
    logic [WIDTH-1:0] o2_q, o2_d;
    logic [WIDTH-1:0] o3_q, o3_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;

    // Next-state logic: slot tracking, shadow capture and frame publish.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        sh2_d         = sh2_q;
        o0_d          = o0_q;
        o1_d          = o1_q;
        o2_d          = o2_q;
        o3_d          = o3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (bus.en) begin
            unique case (state_q)
                HUNT: begin
                    // Samples before the first sync carry no slot position.
                    if (bus.sync) begin
                        sh0_d   = bus.din;
                        cnt_d   = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.sync) begin
                        // A sync anywhere but slot 0 abandons the partial
                        // frame and restarts counting from this sample.
                        sync_err_d = (cnt_q != 2'd0);
                        sh0_d      = bus.din;
                        cnt_d      = 2'd1;
                    end else begin
                        unique case (cnt_q)
                            2'd0: begin
                                // Slot 0 without its marker: alignment lost.
                                sync_err_d = 1'b1;
                                cnt_d      = 2'd0;
                                state_d    = HUNT;
                            end
                            2'd1: begin
                                sh1_d = bus.din;
                                cnt_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d = bus.din;
                                cnt_d = 2'd3;
                            end
                            2'd3: begin
                                o0_d          = sh0_q;
                                o1_d          = sh1_q;
                                o2_d          = sh2_q;
                                o3_d          = bus.din;
                                frame_valid_d = 1'b1;
                                cnt_d         = 2'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; reset clears the partial frame and the published outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow and output registers are reset because a reset must visibly clear o0..o3 to 0.
            state_q       <= HUNT;
            cnt_q         <= 2'd0;
            sh0_q         <= '0;
            sh1_q         <= '0;
            sh2_q         <= '0;
            o0_q          <= '0;
            o1_q          <= '0;
            o2_q          <= '0;
            o3_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh0_q         <= sh0_d;
            sh1_q         <= sh1_d;
            sh2_q         <= sh2_d;
            o0_q          <= o0_d;
            o1_q          <= o1_d;
            o2_q          <= o2_d;
            o3_q          <= o3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.o0          = o0_q;
    assign bus.o1          = o1_q;
    assign bus.o2          = o2_q;
    assign bus.o3          = o3_q;
    assign bus.slot        = cnt_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch (WIDTH=4): a table of per-cycle
// vectors with hand-derived expectations fed through a scoreboard queue,
// plus hand-written asynchronous-reset sequences.
module tb_tdm_demux_4ch;
    localparam int WIDTH = 4;

    typedef struct {
        logic        en;
        logic        sync;
        logic [3:0]  din;
        logic [15:0] o;      // {o0,o1,o2,o3} expected after the edge
        logic [1:0]  slot;
        logic        lk;
        logic        fv;
        logic        err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];
    vec_t exp_q[$];

    tdm_demux_4ch_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux_4ch #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic en, input logic sync, input logic [3:0] din,
                               input logic [15:0] o, input logic [1:0] slot,
                               input logic lk, input logic fv, input logic err);
        vec_t t;
        t.en = en; t.sync = sync; t.din = din; t.o = o;
        t.slot = slot; t.lk = lk; t.fv = fv; t.err = err;
        return t;
    endfunction

    function automatic logic [15:0] outs();
        return {bus.o0, bus.o1, bus.o2, bus.o3};
    endfunction

    // Drive one vector for a clock, queue its expectation, compare after the edge.
    task automatic step(input vec_t t, input string tag);
        vec_t e;
        @(negedge clk);
        bus.en   = t.en;
        bus.sync = t.sync;
        bus.din  = t.din;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_o"},      32'(outs()),           32'(e.o));
            check({tag, "_slot"},   32'(bus.slot),         32'(e.slot));
            check({tag, "_locked"}, 32'(bus.locked),       32'(e.lk));
            check({tag, "_fv"},     32'(bus.frame_valid),  32'(e.fv));
            check({tag, "_err"},    32'(bus.sync_err),     32'(e.err));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_o"},      32'(outs()),          32'h0);
        check({tag, "_slot"},   32'(bus.slot),        32'h0);
        check({tag, "_locked"}, 32'(bus.locked),      32'h0);
        check({tag, "_fv"},     32'(bus.frame_valid), 32'h0);
        check({tag, "_err"},    32'(bus.sync_err),    32'h0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.din  = '0;

        //            en sync din  o0o1o2o3  slot lk fv err
        // Clean frame A,B,C,D
        vecs.push_back(v(1, 1, 4'hA, 16'h0000, 2'd1, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'hB, 16'h0000, 2'd2, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'hC, 16'h0000, 2'd3, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'hD, 16'hABCD, 2'd0, 1, 1, 0));
        // Back-to-back frame 1,2,3,4: frame_valid drops immediately
        vecs.push_back(v(1, 1, 4'h1, 16'hABCD, 2'd1, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h2, 16'hABCD, 2'd2, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h3, 16'hABCD, 2'd3, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h4, 16'h1234, 2'd0, 1, 1, 0));
        // Frame 5,6,7,8 with a 3-cycle gap after slot 1 (junk on din/sync ignored)
        vecs.push_back(v(1, 1, 4'h5, 16'h1234, 2'd1, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h6, 16'h1234, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 4'hF, 16'h1234, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 0, 4'hE, 16'h1234, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 4'h0, 16'h1234, 2'd2, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h7, 16'h1234, 2'd3, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h8, 16'h5678, 2'd0, 1, 1, 0));
        // Early sync at slot 2: partial 9,A dropped, B starts the next frame
        vecs.push_back(v(1, 1, 4'h9, 16'h5678, 2'd1, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'hA, 16'h5678, 2'd2, 1, 0, 0));
        vecs.push_back(v(1, 1, 4'hB, 16'h5678, 2'd1, 1, 0, 1));
        vecs.push_back(v(1, 0, 4'hC, 16'h5678, 2'd2, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'hD, 16'h5678, 2'd3, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'hE, 16'hBCDE, 2'd0, 1, 1, 0));
        // Missing sync on slot 0: lose lock, ignore non-sync samples
        vecs.push_back(v(1, 0, 4'h1, 16'hBCDE, 2'd0, 0, 0, 1));
        vecs.push_back(v(1, 0, 4'h2, 16'hBCDE, 2'd0, 0, 0, 0));
        vecs.push_back(v(1, 0, 4'h3, 16'hBCDE, 2'd0, 0, 0, 0));
        // Relock on the next sync
        vecs.push_back(v(1, 1, 4'h4, 16'hBCDE, 2'd1, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h5, 16'hBCDE, 2'd2, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h6, 16'hBCDE, 2'd3, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h7, 16'h4567, 2'd0, 1, 1, 0));
        vecs.push_back(v(0, 0, 4'h0, 16'h4567, 2'd0, 1, 0, 0));
        // Three slots of a frame, then reset is asserted mid-frame below
        vecs.push_back(v(1, 1, 4'h9, 16'h4567, 2'd1, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h8, 16'h4567, 2'd2, 1, 0, 0));
        vecs.push_back(v(1, 0, 4'h7, 16'h4567, 2'd3, 1, 0, 0));

        // Power-on reset held across several edges
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset mid-cycle, mid-frame: outputs clear with no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;

        // A clean frame decodes correctly after the reset
        step(v(1, 1, 4'h3, 16'h0000, 2'd1, 1, 0, 0), "post0");
        step(v(1, 0, 4'hC, 16'h0000, 2'd2, 1, 0, 0), "post1");
        step(v(1, 0, 4'h5, 16'h0000, 2'd3, 1, 0, 0), "post2");
        step(v(1, 0, 4'hA, 16'h3C5A, 2'd0, 1, 1, 0), "post3");
        step(v(0, 0, 4'h0, 16'h3C5A, 2'd0, 1, 0, 0), "post4");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
